cmd_ctrl: RTL and testbench

Stopwatch command front-end: debounces the three raw push-buttons (start/stop, lap, clear), detects presses and runs the stopwatch control state machine. It drives the 2-bit `comanda` bus of the time-keeping/lap-store stage directly downstream. Lap and clear commands are stretched so the slower divided-clock consumer always samples them, and the block keeps a count of stored laps.

---
 rtl/cmd_ctrl.sv | 140 ++++++++++++++
 tb/tb_cmd_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ctrl.sv
// Stopwatch command front-end: per-button sync + debounce, press detection and the control FSM.
// Optional macro CMD_LAP_LIMIT_EN makes lap_cnt saturate at MAX_LAPS and refuses laps beyond it.
module cmd_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int LAP_HOLD   = 50000000,
  parameter int LAP_W      = 10,
  parameter int MAX_LAPS   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_lap,
  input  logic             btn_clr,
  output logic [1:0]       comanda,
  output logic             running,
  output logic [LAP_W-1:0] lap_cnt
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LAP_HOLD + 1);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP, CLEAR} state_t;

  // bit 0 = start, bit 1 = lap, bit 2 = clr
  logic [2:0] btn;
  logic [2:0] press;

  assign btn = {btn_clr, btn_lap, btn_start};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          press_reg;
      logic [DW-1:0] deb_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          stable_reg  <= 1'b0;
          press_reg   <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg != stable_reg) begin
            // Flip only once the difference has persisted DEB_CYCLES cycles.
            if (deb_cnt_reg == DW'(DEB_CYCLES)) begin
              stable_reg  <= sync2_reg;
              press_reg   <= sync2_reg;
              deb_cnt_reg <= '0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + DW'(1);
            end
          end else begin
            deb_cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [HW-1:0]    hold_reg, hold_next;
  logic [LAP_W-1:0] lap_cnt_reg, lap_cnt_next;
  logic             lap_ok;

`ifdef CMD_LAP_LIMIT_EN
  assign lap_ok = (lap_cnt_reg < LAP_W'(MAX_LAPS));
`else
  assign lap_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      lap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      lap_cnt_reg <= lap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    lap_cnt_next = lap_cnt_reg;
    case (state_reg)
      IDLE, PAUSE: begin
        if (press[2]) begin
          state_next   = CLEAR;
          hold_next    = '0;
          lap_cnt_next = '0;
        end else if (press[0]) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A clr pulse is refused here but still outranks start and lap.
        if (!press[2]) begin
          if (press[0]) begin
            state_next = PAUSE;
          end else if (press[1] && lap_ok) begin
            state_next   = LAP;
            hold_next    = '0;
            lap_cnt_next = lap_cnt_reg + LAP_W'(1);
          end
        end
      end
      LAP, CLEAR: begin
        if (hold_reg == HW'(LAP_HOLD - 1)) begin
          state_next = (state_reg == LAP) ? RUN : IDLE;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    comanda = 2'b00;
    running = 1'b0;
    case (state_reg)
      RUN:     begin comanda = 2'b01; running = 1'b1; end
      LAP:     begin comanda = 2'b10; running = 1'b1; end
      CLEAR:   comanda = 2'b11;
      default: comanda = 2'b00;
    endcase
  end

  assign lap_cnt = lap_cnt_reg;

endmodule

// File: tb/tb_cmd_ctrl.sv
// Directed self-checking bench for cmd_ctrl (DEB_CYCLES=4, LAP_HOLD=3, LAP_W=3, MAX_LAPS=5).
// Expectations follow CMD_LAP_LIMIT_EN when the macro is defined for the build.
module tb_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic [1:0] comanda;
  logic       running;
  logic [2:0] lap_cnt;

  int tests = 0;
  int fails = 0;

  cmd_ctrl #(
    .DEB_CYCLES(4),
    .LAP_HOLD(3),
    .LAP_W(3),
    .MAX_LAPS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start(btn_start),
    .btn_lap(btn_lap),
    .btn_clr(btn_clr),
    .comanda(comanda),
    .running(running),
    .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Raise the masked buttons (bit0 start, bit1 lap, bit2 clr) and wait until
  // the resulting press has reached the state register.
  task automatic press(input logic [2:0] m);
    btn_start = m[0];
    btn_lap   = m[1];
    btn_clr   = m[2];
    repeat (8) tick();
  endtask

  task automatic release_all();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clr   = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int exp_cnt;
    int exp_cmd;

    repeat (2) tick();
    rst = 1'b0;
    chk("reset comanda", comanda, 0);
    chk("reset running", running, 0);
    chk("reset lap_cnt", lap_cnt, 0);

    // Bounce: toggles every 2 cycles never survive the debounce window.
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      repeat (2) tick();
    end
    btn_start = 1'b0;
    repeat (8) tick();
    chk("bounce ignored", comanda, 0);

    // First press: raw first sampled on tick 1, state updates on tick 8.
    btn_start = 1'b1;
    repeat (7) tick();
    chk("start latency pre", comanda, 0);
    tick();
    chk("start -> RUN", comanda, 1);
    chk("running in RUN", running, 1);
    repeat (2) tick();
    release_all();
    chk("held press single", comanda, 1);

    press(3'b001);
    chk("start -> PAUSE", comanda, 0);
    chk("running in PAUSE", running, 0);
    release_all();
    press(3'b001);
    chk("start -> RUN again", comanda, 1);
    release_all();

    // Lap, with a start press landing one cycle later, inside the hold.
    btn_lap = 1'b1;
    tick();
    btn_start = 1'b1;
    repeat (7) tick();
    chk("lap hold c1", comanda, 2);
    chk("lap_cnt after lap", lap_cnt, 1);
    tick();
    chk("lap hold c2", comanda, 2);
    tick();
    chk("lap hold c3", comanda, 2);
    tick();
    chk("lap hold end", comanda, 1);
    chk("press in LAP dropped", lap_cnt, 1);
    release_all();
    chk("no extra hold", comanda, 1);

    press(3'b100);
    chk("clr in RUN ignored", comanda, 1);
    release_all();
    press(3'b001);
    chk("PAUSE before clr", comanda, 0);
    release_all();
    press(3'b100);
    chk("clear c1", comanda, 3);
    chk("clear zeroes lap_cnt", lap_cnt, 0);
    tick();
    chk("clear c2", comanda, 3);
    tick();
    chk("clear c3", comanda, 3);
    tick();
    chk("clear -> IDLE", comanda, 0);
    chk("running in IDLE", running, 0);
    release_all();

    // Simultaneous start+clr in PAUSE: clr wins.
    press(3'b001);
    release_all();
    press(3'b010);
    chk("lap before pause", lap_cnt, 1);
    release_all();
    press(3'b001);
    chk("pause for simul", comanda, 0);
    release_all();
    press(3'b101);
    chk("start+clr -> CLEAR", comanda, 3);
    chk("start+clr lap_cnt", lap_cnt, 0);
    release_all();
    chk("after simul clear", comanda, 0);

    // Simultaneous start+lap in RUN: start wins.
    press(3'b001);
    release_all();
    press(3'b011);
    chk("start+lap -> PAUSE", comanda, 0);
    chk("start+lap lap_cnt", lap_cnt, 0);
    release_all();
    press(3'b001);
    release_all();

    for (int i = 1; i <= 9; i++) begin
`ifdef CMD_LAP_LIMIT_EN
      exp_cnt = (i <= 5) ? i : 5;
      exp_cmd = (i <= 5) ? 2 : 1;
`else
      exp_cnt = i % 8;
      exp_cmd = 2;
`endif
      press(3'b010);
      chk($sformatf("lap%0d comanda", i), comanda, exp_cmd);
      chk($sformatf("lap%0d lap_cnt", i), lap_cnt, exp_cnt);
      release_all();
    end
    chk("laps end RUN", comanda, 1);

    // Reset in the middle of a lap hold.
`ifdef CMD_LAP_LIMIT_EN
    exp_cmd = 1;
`else
    exp_cmd = 2;
`endif
    press(3'b010);
    chk("pre-reset lap", comanda, exp_cmd);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-LAP rst comanda", comanda, 0);
    chk("mid-LAP rst running", running, 0);
    chk("mid-LAP rst lap_cnt", lap_cnt, 0);
    repeat (8) tick();
    chk("held lap in IDLE", comanda, 0);
    release_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
